// File: rtl/kalman_track_mc.sv
// Multi-channel 2-state (angle, rate) Kalman filter in signed Q(FRAC), one shared datapath.
// Define KF_INNOV_GATE_EN to compile in innovation gating (outlier rejection).
module kalman_track_mc #(
    parameter int WIDTH    = 16,
    parameter int FRAC     = 14,
    parameter int CHANNELS = 2,
    parameter int DT       = 164,
    parameter int Q_ANG    = 16,
    parameter int Q_RATE   = 16,
    parameter int R_MEAS   = 1638,
    parameter int P_INIT   = 16384,
`ifdef KF_INNOV_GATE_EN
    parameter int GATE     = 8192,
`endif
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [CW-1:0]           ch_id,
    input  logic signed [WIDTH-1:0] meas,
    output logic                    busy,
    output logic                    finish,
    output logic [CW-1:0]           ch_out,
    output logic signed [WIDTH-1:0] angle_est,
    output logic signed [WIDTH-1:0] rate_est,
    output logic                    div_err,
    output logic                    outlier
);

    localparam int EW   = WIDTH + 4;
    localparam int DW   = 2 * WIDTH;
    localparam int CWP  = CW + 1;
    localparam int CNTW = $clog2(WIDTH);

    localparam logic [3:0] StIdle  = 4'd0;
    localparam logic [3:0] StLoad  = 4'd1;
    localparam logic [3:0] StPredX = 4'd2;
    localparam logic [3:0] StPredP = 4'd3;
    localparam logic [3:0] StCalcS = 4'd4;
    localparam logic [3:0] StDiv   = 4'd5;
    localparam logic [3:0] StGain  = 4'd6;
    localparam logic [3:0] StInnov = 4'd7;
    localparam logic [3:0] StUpdX  = 4'd8;
    localparam logic [3:0] StUpdP  = 4'd9;
    localparam logic [3:0] StDone  = 4'd10;

    localparam logic signed [EW-1:0]    W_MAX    = EW'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [EW-1:0]    W_MIN    = ~W_MAX;
    localparam logic signed [EW-1:0]    X_MAX    = EW'((1 << (WIDTH + 1)) - 1);
    localparam logic signed [EW-1:0]    X_MIN    = ~X_MAX;
    localparam logic signed [WIDTH-1:0] DT_W     = WIDTH'(DT);
    localparam logic signed [WIDTH-1:0] Q_ANG_W  = WIDTH'(Q_ANG);
    localparam logic signed [WIDTH-1:0] Q_RATE_W = WIDTH'(Q_RATE);
    localparam logic signed [WIDTH-1:0] R_W      = WIDTH'(R_MEAS);
    localparam logic signed [WIDTH-1:0] P_INIT_W = WIDTH'(P_INIT);
    localparam logic [DW-1:0]           DIVIDEND = DW'(1) << (2 * FRAC);
    localparam logic [CWP-1:0]          CH_LIM   = CWP'(CHANNELS);
    localparam logic [CNTW-1:0]         CNT_LAST = CNTW'(WIDTH - 1);

    function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [EW-1:0] v);
        if (v > W_MAX) return W_MAX[WIDTH-1:0];
        if (v < W_MIN) return W_MIN[WIDTH-1:0];
        return v[WIDTH-1:0];
    endfunction

    function automatic logic signed [EW-1:0] ext(input logic signed [WIDTH-1:0] v);
        return EW'(v);
    endfunction

    // Full-width product, shifted back to Q(FRAC), clamped to WIDTH+2 bits.
    function automatic logic signed [EW-1:0] mulq(input logic signed [WIDTH-1:0] x,
                                                  input logic signed [WIDTH-1:0] y);
        logic signed [DW-1:0] p;
        p = (DW'(x) * DW'(y)) >>> FRAC;
        if (p > DW'(X_MAX)) return X_MAX;
        if (p < DW'(X_MIN)) return X_MIN;
        return EW'(p);
    endfunction

    logic signed [WIDTH-1:0] a_mem   [CHANNELS];
    logic signed [WIDTH-1:0] r_mem   [CHANNELS];
    logic signed [WIDTH-1:0] p11_mem [CHANNELS];
    logic signed [WIDTH-1:0] p12_mem [CHANNELS];
    logic signed [WIDTH-1:0] p22_mem [CHANNELS];

    logic [3:0]              state_q;
    logic [CW-1:0]           ch_q;
    logic signed [WIDTH-1:0] z_q, a_q, r_q, p11_q, p12_q, p22_q;
    logic signed [WIDTH-1:0] s_q, k1_q, k2_q, y_q;
    logic [WIDTH-1:0]        rem_q, num_q, quo_q;
    logic [CNTW-1:0]         cnt_q;
    logic                    ovf_q, derr_q;
    logic                    upd_en;

    logic signed [WIDTH-1:0] pred_a, dt_p22, pred_p11, pred_p12, pred_p22, s_n;
    logic signed [WIDTH-1:0] inv, k1_n, k2_n, y_n;
    logic signed [WIDTH-1:0] upd_a, upd_r, upd_p11, upd_p12, upd_p22;
    logic [DW-1:0]           s_scaled;
    logic [WIDTH:0]          trial, divisor;
    logic                    ge;

    always_comb begin
        pred_a   = sat_w(ext(a_q) + mulq(DT_W, r_q));
        dt_p22   = sat_w(mulq(DT_W, p22_q));
        pred_p11 = sat_w(ext(p11_q) + (mulq(DT_W, p12_q) <<< 1) + mulq(DT_W, dt_p22)
                         + ext(Q_ANG_W));
        pred_p12 = sat_w(ext(p12_q) + mulq(DT_W, p22_q));
        pred_p22 = sat_w(ext(p22_q) + ext(Q_RATE_W));
        s_n      = sat_w(ext(p11_q) + ext(R_W));
        // Quotient would not fit in WIDTH-1 magnitude bits when S * 2^(WIDTH-1) <= dividend.
        s_scaled = DW'($unsigned(s_n)) << (WIDTH - 1);
        trial    = {rem_q, num_q[WIDTH-1]};
        divisor  = {1'b0, $unsigned(s_q)};
        ge       = (trial >= divisor);
        inv      = ovf_q ? W_MAX[WIDTH-1:0] : $signed(quo_q);
        k1_n     = sat_w(mulq(p11_q, inv));
        k2_n     = sat_w(mulq(p12_q, inv));
        y_n      = sat_w(ext(z_q) - ext(a_q));
        upd_a    = sat_w(ext(a_q) + mulq(k1_q, y_q));
        upd_r    = sat_w(ext(r_q) + mulq(k2_q, y_q));
        upd_p11  = sat_w(ext(p11_q) - mulq(k1_q, p11_q));
        upd_p12  = sat_w(ext(p12_q) - mulq(k1_q, p12_q));
        upd_p22  = sat_w(ext(p22_q) - mulq(k2_q, p12_q));
    end

    assign busy = (state_q != StIdle) || finish;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            ch_q      <= '0;
            z_q       <= '0;
            a_q       <= '0;
            r_q       <= '0;
            p11_q     <= '0;
            p12_q     <= '0;
            p22_q     <= '0;
            s_q       <= '0;
            k1_q      <= '0;
            k2_q      <= '0;
            y_q       <= '0;
            rem_q     <= '0;
            num_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            derr_q    <= 1'b0;
            finish    <= 1'b0;
            ch_out    <= '0;
            angle_est <= '0;
            rate_est  <= '0;
            div_err   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                a_mem[i]   <= '0;
                r_mem[i]   <= '0;
                p11_mem[i] <= P_INIT_W;
                p12_mem[i] <= '0;
                p22_mem[i] <= P_INIT_W;
            end
        end else begin
            finish <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start && !finish && ({1'b0, ch_id} < CH_LIM)) begin
                        ch_q    <= ch_id;
                        z_q     <= meas;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    a_q     <= a_mem[ch_q];
                    r_q     <= r_mem[ch_q];
                    p11_q   <= p11_mem[ch_q];
                    p12_q   <= p12_mem[ch_q];
                    p22_q   <= p22_mem[ch_q];
                    state_q <= StPredX;
                end
                StPredX: begin
                    a_q     <= pred_a;
                    state_q <= StPredP;
                end
                StPredP: begin
                    p11_q   <= pred_p11;
                    p12_q   <= pred_p12;
                    p22_q   <= pred_p22;
                    state_q <= StCalcS;
                end
                StCalcS: begin
                    s_q     <= s_n;
                    rem_q   <= DIVIDEND[DW-1:WIDTH];
                    num_q   <= DIVIDEND[WIDTH-1:0];
                    quo_q   <= '0;
                    cnt_q   <= '0;
                    derr_q  <= (s_n <= 0);
                    ovf_q   <= (s_n <= 0) || (s_scaled <= DIVIDEND);
                    state_q <= StDiv;
                end
                StDiv: begin
                    rem_q <= ge ? WIDTH'(trial - divisor) : trial[WIDTH-1:0];
                    num_q <= num_q << 1;
                    quo_q <= {quo_q[WIDTH-2:0], ge};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_q <= StGain;
                end
                StGain: begin
                    k1_q    <= k1_n;
                    k2_q    <= k2_n;
                    state_q <= StInnov;
                end
                StInnov: begin
                    y_q     <= y_n;
                    state_q <= StUpdX;
                end
                StUpdX: begin
                    if (upd_en) begin
                        a_q <= upd_a;
                        r_q <= upd_r;
                    end
                    state_q <= StUpdP;
                end
                StUpdP: begin
                    if (upd_en) begin
                        p11_q <= upd_p11;
                        p12_q <= upd_p12;
                        p22_q <= upd_p22;
                    end
                    state_q <= StDone;
                end
                StDone: begin
                    a_mem[ch_q]   <= a_q;
                    r_mem[ch_q]   <= r_q;
                    p11_mem[ch_q] <= p11_q;
                    p12_mem[ch_q] <= p12_q;
                    p22_mem[ch_q] <= p22_q;
                    ch_out        <= ch_q;
                    angle_est     <= a_q;
                    rate_est      <= r_q;
                    div_err       <= derr_q;
                    finish        <= 1'b1;
                    state_q       <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef KF_INNOV_GATE_EN
    localparam logic signed [EW-1:0] GATE_E = EW'(GATE);
    logic gated_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            gated_q <= 1'b0;
            outlier <= 1'b0;
        end else begin
            if (state_q == StInnov) gated_q <= (ext(y_n) > GATE_E) || (ext(y_n) < -GATE_E);
            if (state_q == StDone) outlier <= gated_q;
        end
    end

    assign upd_en = !gated_q;
`else
    assign upd_en  = 1'b1;
    assign outlier = 1'b0;
`endif

endmodule

// File: tb/tb_kalman_track_mc.sv
// Scoreboard bench for kalman_track_mc: random and directed steps against a behavioural model.
module tb_kalman_track_mc;

    // Three channels so that an out-of-range ch_id (3) is representable.
    localparam int     CH     = 3;
    localparam int     W      = 16;
    localparam int     FRAC   = 14;
    localparam longint DT     = 164;
    localparam longint Q_ANG  = 16;
    localparam longint Q_RATE = 16;
    localparam longint R_MEAS = 1638;
    localparam longint P_INIT = 16384;
    localparam longint MAXW   = 32767;
    localparam int     LAT    = W + 9;
`ifdef KF_INNOV_GATE_EN
    localparam longint GATE_TB = 8192;
`endif

    logic                clk = 1'b0;
    logic                reset, start;
    logic [1:0]          ch_id;
    logic signed [W-1:0] meas;
    logic                busy, finish, div_err, outlier;
    logic [1:0]          ch_out;
    logic signed [W-1:0] angle_est, rate_est;

    kalman_track_mc #(.CHANNELS(CH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ch_id     (ch_id),
        .meas      (meas),
        .busy      (busy),
        .finish    (finish),
        .ch_out    (ch_out),
        .angle_est (angle_est),
        .rate_est  (rate_est),
        .div_err   (div_err),
        .outlier   (outlier)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     ch;
        longint ang;
        longint rate;
        bit     derr;
        bit     outl;
        int     acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic chk_range(input string name, input longint act, input longint lo,
                             input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=[%0d..%0d]", name, act, lo, hi);
        end
    endtask

    // Behavioural model: per-channel state kept as plain integers.
    longint ma[CH], mr[CH], m11[CH], m12[CH], m22[CH];

    function automatic longint clampb(input longint v, input int bits);
        longint hi, lo;
        hi = (longint'(1) <<< (bits - 1)) - 1;
        lo = -hi - 1;
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic longint qmul(input longint x, input longint y);
        return clampb((x * y) >>> FRAC, W + 2);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            ma[c]  = 0;
            mr[c]  = 0;
            m11[c] = P_INIT;
            m12[c] = 0;
            m22[c] = P_INIT;
        end
    endtask

    task automatic model_step(input int c, input longint z, output exp_t e);
        longint a, r, p11, p12, p22, dtp22, s, inv, k1, k2, y;
        bit derr, gated;
        a     = clampb(ma[c] + qmul(DT, mr[c]), W);
        r     = mr[c];
        dtp22 = clampb(qmul(DT, m22[c]), W);
        p11   = clampb(m11[c] + 2 * qmul(DT, m12[c]) + qmul(DT, dtp22) + Q_ANG, W);
        p12   = clampb(m12[c] + qmul(DT, m22[c]), W);
        p22   = clampb(m22[c] + Q_RATE, W);
        s     = clampb(p11 + R_MEAS, W);
        derr  = (s <= 0);
        if (derr) inv = MAXW;
        else begin
            inv = (longint'(1) <<< (2 * FRAC)) / s;
            if (inv > MAXW) inv = MAXW;
        end
        k1    = clampb(qmul(p11, inv), W);
        k2    = clampb(qmul(p12, inv), W);
        y     = clampb(z - a, W);
        gated = 1'b0;
`ifdef KF_INNOV_GATE_EN
        gated = (y > GATE_TB) || (y < -GATE_TB);
`endif
        if (!gated) begin
            ma[c]  = clampb(a + qmul(k1, y), W);
            mr[c]  = clampb(r + qmul(k2, y), W);
            m11[c] = clampb(p11 - qmul(k1, p11), W);
            m12[c] = clampb(p12 - qmul(k1, p12), W);
            m22[c] = clampb(p22 - qmul(k2, p12), W);
        end else begin
            ma[c]  = a;
            mr[c]  = r;
            m11[c] = p11;
            m12[c] = p12;
            m22[c] = p22;
        end
        e.ch   = c;
        e.ang  = ma[c];
        e.rate = mr[c];
        e.derr = derr;
        e.outl = gated;
        e.acc  = 0;
    endtask

    // Monitor: every finish pulse is matched against the oldest expected result.
    always @(negedge clk) begin
        if (finish) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_finish ch_out=%0d angle=%0d", ch_out, angle_est);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ch_out", ch_out, e.ch);
                chk("angle_est", angle_est, e.ang);
                chk("rate_est", rate_est, e.rate);
                chk("div_err", div_err, e.derr);
                chk("outlier", outlier, e.outl);
                chk("latency", cyc - e.acc, LAT);
            end
        end
    end

    // Called at a negedge; issues one accepted step and records its expectation.
    task automatic step(input int c, input longint z);
        exp_t e;
        int   n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL wait_idle busy=%0d required=0", busy);
        end
        model_step(c, z, e);
        e.acc = cyc + 1;
        exp_q.push_back(e);
        start = 1'b1;
        ch_id = c[1:0];
        meas  = z[15:0];
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_fin();
        int n;
        n = 0;
        while (!finish && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!finish) begin
            checks++;
            failures++;
            $display("FAIL finish_timeout finish=%0d required=1", finish);
        end
    endtask

    task automatic pulse_start(input int c, input longint z);
        start = 1'b1;
        ch_id = c[1:0];
        meas  = z[15:0];
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int nb, nf;
        reset = 1'b1;
        start = 1'b0;
        ch_id = '0;
        meas  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_angle", angle_est, 0);
        chk("reset_rate", rate_est, 0);
        chk("reset_busy", busy, 0);
        chk("reset_finish", finish, 0);
        chk("reset_ch_out", ch_out, 0);
        chk("reset_div_err", div_err, 0);
        chk("reset_outlier", outlier, 0);

        pulse_start(3, 1234);
        nb = 0;
        repeat (30) begin
            @(negedge clk);
            nb += busy;
        end
        chk("bad_ch_busy_cycles", nb, 0);

        step(0, 8192);
        wait_fin();
        chk_range("ch0_first_angle", angle_est, 7444, 7452);
        chk_range("ch0_first_rate", rate_est, 70, 78);
        chk("ch0_first_div_err", div_err, 0);

        step(1, 8192);
        wait_fin();
        chk_range("ch1_first_angle", angle_est, 7444, 7452);
        chk_range("ch1_first_rate", rate_est, 70, 78);

        step(0, 8192);
        wait_fin();
        chk_range("ch0_second_closer", angle_est, 7449, 8935);

        // Starts while busy must be dropped, not queued.
        step(1, -5000);
        repeat (2) @(negedge clk);
        pulse_start(0, 777);
        repeat (4) @(negedge clk);
        pulse_start(2, -3000);
        repeat (5) @(negedge clk);
        pulse_start(1, 12000);
        wait_fin();
        @(negedge clk);
        chk("busy_ignore_queue", exp_q.size(), 0);
        nb = 0;
        repeat (30) begin
            @(negedge clk);
            nb += busy;
        end
        chk("busy_ignore_idle", nb, 0);

        for (int i = 0; i < 30; i++) begin
            step(int'($urandom_range(0, CH - 1)), longint'($urandom_range(0, 40000)) - 20000);
            wait_fin();
        end

        for (int i = 0; i < 50; i++) begin
            step(0, 32767);
            wait_fin();
            chk_range("sat_angle", angle_est, 0, 32767);
        end

        // Reset in the middle of the division aborts the step.
        step(0, 8192);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        nf = 0;
        repeat (40) begin
            @(negedge clk);
            nf += finish;
        end
        chk("abort_no_finish", nf, 0);
        chk("abort_busy", busy, 0);
        step(0, 8192);
        wait_fin();
        chk_range("after_abort_angle", angle_est, 7444, 7452);

        step(1, 0);
        wait_fin();
        step(1, 20000);
        wait_fin();
`ifdef KF_INNOV_GATE_EN
        chk("gate_outlier", outlier, 1);
        chk("gate_angle_pred", angle_est, 0);
`else
        chk("nogate_outlier", outlier, 0);
        chk_range("nogate_angle_updated", angle_est, 1, 32767);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout time=%0t", $time);
        $fatal(1);
    end

endmodule
